golden_nonce_reporter: RTL and testbench
========================================

// Module: golden_nonce_reporter
// PURPOSE
//  Result-path transmitter from the hasher to the NIOS controller; the work path runs controller -> hasher.
//  Captures golden-ticket nonces and subtracts the hasher pipeline offset.
//  Buffers them in a small FIFO and presents them one at a time on a 32-bit PIO-facing port with a valid/ack handshake.
//  Sits in fpgaminer_top between the is_golden_ticket/nonce logic and the controller's pio_nonce input.
// PARAMETERS
//  DEPTH         8    FIFO entries; power of two, 2..64
//  NONCE_OFFSET  132  pipeline offset subtracted from every captured nonce
// PORTS
//  clk          in   1   hash clock; sole clock
//  reset        in   1   asynchronous, active-high reset
//  found        in   1   golden ticket flag for this cycle (is_golden_ticket)
//  found_nonce  in   32  raw nonce accompanying found
//  flush        in   1   new work loaded; discard all pending nonces
//  ack          in   1   controller PIO level; rising edge pops head entry
//  nonce_out    out  32  head entry (offset-corrected); 0 when empty
//  nonce_valid  out  1   nonce_out holds an unread nonce
//  fifo_count   out  $clog2(DEPTH)+1  entries held
//  overflow     out  1   sticky: at least one nonce dropped since reset/flush
//  drop_count   out  8   dropped nonces, saturates at 255
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFO empty; all outputs 0; ack edge detector's previous-ack register = 0.
//  - Capture: found=1 at edge N -> entry {found_nonce - NONCE_OFFSET} mod 2^32 written at edge N.
//    nonce_valid/nonce_out update after edge N if FIFO was empty.
//    Every cycle with found=1 is a distinct push (back-to-back allowed).
//  - Wrap: 0x00000010 - 132 = 0xFFFFFF8C; no saturation.
//  - Pop: ack_q<=ack; pop = ack & ~ack_q & nonce_valid.
//    Pop advances head at that edge; next entry or empty is visible after that edge.
//    A rising edge of ack while empty is ignored and not remembered.
//  - Full: push without pop is dropped; overflow<=1; drop_count+=1 (sat 255).
//    Full with push+pop in the same cycle: both happen, no drop.
//  - Empty: push+pop cannot coincide; pop requires valid.
//  - flush: highest priority. At that edge count=0, valid=0, nonce_out=0, overflow=0, drop_count=0.
//    A same-cycle push or pop is discarded. ack_q still tracks ack.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. fifo_count = wr-rd with an extra MSB to distinguish full from empty.
//  - Outputs are registered; no combinational path from any input to any output.
// CONFIGURATION
//  GNR_DUP_FILTER_EN defined:
//    - Push suppressed when corrected nonce equals the last accepted nonce (register cleared by reset/flush; reset value also 0).
//    - Handles a found flag held across a stalled nonce counter.
//    - A suppressed push is not a drop.
//  Undefined: every found cycle pushes.
// STRUCTURE
//  - Package gnr_pkg:
//    - NONCE_W=32
//    - DEFAULT_NONCE_OFFSET=32'd132
//    - DROP_W=8
//    - typedef nonce_t (logic [NONCE_W-1:0])
//  - Sub-module gnr_fifo:
//    - synchronous DEPTH x 32 FIFO with push/pop/flush and registered head output
//    - provides full/empty/count
//  - Top adds offset subtract, ack edge detect, drop accounting and the dup filter.
// TESTING
//  1. Reset, found=1 with 0x00001000 -> next cycle nonce_valid=1, nonce_out=0x00000F7C, fifo_count=1.
//  2. found with 0x00000010 -> nonce_out=0xFFFFFF8C (wrap).
//  3. Eight back-to-back founds (0x100..0x107), then ack toggled eight times:
//     - nonce_out steps 0x7C..0x83 in order, then valid=0, nonce_out=0.
//     - Holding ack high for 5 cycles pops exactly one entry.
//  4. Full (8 entries):
//     - found alone -> overflow=1, drop_count=1, count stays 8.
//     - found + ack rising same cycle -> count stays 8, no new drop.
//     - 300 extra founds -> drop_count=255.
//  5. Three entries plus overflow set, flush and found in the same cycle -> count=0, valid=0, overflow=0, drop_count=0.
//     Then reset asserted mid-stream -> all outputs 0 immediately (async).
//  6. GNR_DUP_FILTER_EN:
//     - found held 4 cycles with nonce fixed at 0x200 -> count=1.
//     - Undefined: count=4.

Source files
------------

// File: rtl/gnr_pkg.sv
// Shared types and constants for the golden nonce reporter.
package gnr_pkg;

  localparam int unsigned NONCE_W = 32;
  localparam logic [31:0] DEFAULT_NONCE_OFFSET = 32'd132;
  localparam int unsigned DROP_W = 8;

  typedef logic [NONCE_W-1:0] nonce_t;

  // Saturating increment for the drop counter; holds at all-ones.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/gnr_fifo.sv
// Synchronous DEPTH x 32 FIFO with flush and a registered head output.
// The head register shows the oldest entry (0 when empty), so the
// consumer never sees a combinational path through the storage array.
module gnr_fifo
  import gnr_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  nonce_t                   wdata_i,
  output nonce_t                   head_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  nonce_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d, rd_nxt;
  logic [CW-1:0]   cnt_q, cnt_d;
  nonce_t          head_q, head_d;
  logic            valid_q, valid_d;
  logic            do_push, do_pop, full;

  assign full   = (cnt_q == CW'(DEPTH));
  assign rd_nxt = rd_q + AW'(1);

  // Next-state: pointers, count and head; flush overrides everything.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    valid_d = valid_q;
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      head_d  = '0;
      valid_d = 1'b0;
    end else begin
      do_pop  = pop_i & valid_q;
      // A full FIFO still accepts a write when the head leaves this cycle.
      do_push = push_i & (~full | do_pop);
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_nxt;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
      if (do_pop) begin
        // With one entry left the successor is either the incoming word or nothing.
        if (cnt_q == CW'(1)) head_d = do_push ? wdata_i : '0;
        else                 head_d = mem_q[rd_nxt];
      end else if (do_push && cnt_q == '0) begin
        head_d = wdata_i;
      end
      valid_d = (cnt_d != '0);
    end
  end

  // Storage array write; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  // Control and head registers.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      valid_q <= valid_d;
    end
  end

  assign head_o  = head_q;
  assign valid_o = valid_q;
  assign count_o = cnt_q;
  assign full_o  = full;

endmodule

// File: rtl/golden_nonce_reporter.sv
// Golden nonce reporter: captures hasher golden-ticket nonces, removes the
// hasher pipeline offset, queues them and hands them to the controller
// one at a time on a rising edge of its ack level.
// Optional build macro GNR_DUP_FILTER_EN suppresses repeat pushes of the
// last accepted nonce (found held while the nonce counter is stalled).
module golden_nonce_reporter
  import gnr_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter nonce_t      NONCE_OFFSET = DEFAULT_NONCE_OFFSET
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   found,
  input  logic [31:0]            found_nonce,
  input  logic                   flush,
  input  logic                   ack,
  output logic [31:0]            nonce_out,
  output logic                   nonce_valid,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic [7:0]             drop_count
);

  nonce_t            corr;
  logic              ack_q;
  logic              pop_w, push_w, drop_w, dup, full;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  // Wraps modulo 2^32 by construction; no saturation wanted here.
  assign corr   = found_nonce - NONCE_OFFSET;
  assign pop_w  = ack & ~ack_q & nonce_valid;
  assign push_w = found & ~dup;
  assign drop_w = push_w & full & ~pop_w & ~flush;

`ifdef GNR_DUP_FILTER_EN
  nonce_t last_q, last_d;
  logic   accepted;

  assign dup      = (corr == last_q);
  assign accepted = push_w & (~full | pop_w);

  // Remember the last nonce actually written into the FIFO.
  always_comb begin
    last_d = last_q;
    if (flush)         last_d = '0;
    else if (accepted) last_d = corr;
  end

  // Last-accepted register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= '0;
    else       last_q <= last_d;
  end
`else
  assign dup = 1'b0;
`endif

  // Drop accounting: sticky overflow and saturating counter, both cleared by flush.
  always_comb begin
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (flush) begin
      overflow_d = 1'b0;
      drop_d     = '0;
    end else if (drop_w) begin
      overflow_d = 1'b1;
      drop_d     = sat_inc(drop_q);
    end
  end

  // Ack edge detector history and drop registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q      <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      ack_q      <= ack;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  gnr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_i   (reset),
    .push_i  (push_w),
    .pop_i   (pop_w),
    .flush_i (flush),
    .wdata_i (corr),
    .head_o  (nonce_out),
    .valid_o (nonce_valid),
    .count_o (fifo_count),
    .full_o  (full)
  );

  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_golden_nonce_reporter.sv
// Bench for golden_nonce_reporter: vector table plus a queue scoreboard
// model updated on every driven cycle, with hand-written corner sequences.
module tb_golden_nonce_reporter;

  localparam int DEPTH = 8;
  localparam logic [31:0] OFS = 32'd132;

  logic        clk = 1'b0;
  logic        reset;
  logic        found;
  logic [31:0] found_nonce;
  logic        flush;
  logic        ack;
  logic [31:0] nonce_out;
  logic        nonce_valid;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [7:0]  drop_count;

  golden_nonce_reporter #(.DEPTH(DEPTH), .NONCE_OFFSET(OFS)) dut (
    .clk         (clk),
    .reset       (reset),
    .found       (found),
    .found_nonce (found_nonce),
    .flush       (flush),
    .ack         (ack),
    .nonce_out   (nonce_out),
    .nonce_valid (nonce_valid),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard model state
  logic [31:0] sb[$];
  logic        m_ovf;
  logic [7:0]  m_drop;
  logic        m_ack_prev;
  logic [31:0] m_last;

  typedef struct {
    logic        f;
    logic [31:0] n;
    logic        a;
    logic        fl;
    logic        e_valid;
    logic [31:0] e_out;
    logic [3:0]  e_count;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_ovf      = 1'b0;
    m_drop     = 8'd0;
    m_ack_prev = 1'b0;
    m_last     = 32'd0;
  endtask

  // Compare all DUT outputs against the model.
  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, {31'd0, nonce_valid}, {31'd0, (sb.size() > 0)});
    chk({tag, ".out"},   nonce_out, (sb.size() > 0) ? sb[0] : 32'd0);
    chk({tag, ".count"}, {28'd0, fifo_count}, 32'(sb.size()));
    chk({tag, ".ovf"},   {31'd0, overflow}, {31'd0, m_ovf});
    chk({tag, ".drop"},  {24'd0, drop_count}, {24'd0, m_drop});
  endtask

  // Drive one cycle, advance the model, compare after the edge.
  task automatic step(input logic f, input logic [31:0] n, input logic a,
                      input logic fl, input string tag, input bit do_chk);
    logic        pop, push, full;
    logic [31:0] c;
    @(negedge clk);
    found = f; found_nonce = n; ack = a; flush = fl;
    c    = n - OFS;
    pop  = a && !m_ack_prev && (sb.size() > 0);
    m_ack_prev = a;
    if (fl) begin
      sb.delete();
      m_ovf  = 1'b0;
      m_drop = 8'd0;
      m_last = 32'd0;
    end else begin
      push = f;
`ifdef GNR_DUP_FILTER_EN
      if (c == m_last) push = 1'b0;
`endif
      full = (sb.size() == DEPTH);
      if (pop) void'(sb.pop_front());
      if (push) begin
        if (!full || pop) begin
          sb.push_back(c);
          m_last = c;
        end else begin
          m_ovf = 1'b1;
          if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (do_chk) chk_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; found = 0; found_nonce = 0; ack = 0; flush = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; found = 0; found_nonce = 0; ack = 0; flush = 0;
    model_reset();
    do_reset();
    #1;
    chk("reset.valid", {31'd0, nonce_valid}, 32'd0);
    chk("reset.out",   nonce_out, 32'd0);
    chk("reset.count", {28'd0, fifo_count}, 32'd0);
    chk("reset.ovf",   {31'd0, overflow}, 32'd0);
    chk("reset.drop",  {24'd0, drop_count}, 32'd0);

    // Vector table: capture, pop to empty, wrap capture, hold, pop.
    vecs[0] = '{1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b1, 32'h0000_0F7C, 4'd1};
    vecs[1] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         4'd0};
    vecs[2] = '{1'b1, 32'h0000_0010, 1'b0, 1'b0, 1'b1, 32'hFFFF_FF8C, 4'd1};
    vecs[3] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hFFFF_FF8C, 4'd1};
    vecs[4] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         4'd0};
    for (int i = 0; i < 5; i++) begin
      step(vecs[i].f, vecs[i].n, vecs[i].a, vecs[i].fl, $sformatf("vec%0d", i), 1'b1);
      chk($sformatf("tbl%0d.valid", i), {31'd0, nonce_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("tbl%0d.out", i),   nonce_out, vecs[i].e_out);
      chk($sformatf("tbl%0d.count", i), {28'd0, fifo_count}, {28'd0, vecs[i].e_count});
    end
    step(0, 0, 0, 0, "idle", 1'b1);

    // Eight back-to-back captures, then eight ack toggles in order.
    for (int i = 0; i < 8; i++) step(1, 32'h100 + i, 0, 0, "fill8", 1'b1);
    chk("fill8.count", {28'd0, fifo_count}, 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("drain.head", nonce_out, 32'h7C + i);
      step(0, 0, 1, 0, "drain.hi", 1'b1);
      step(0, 0, 0, 0, "drain.lo", 1'b1);
    end
    chk("drain.valid", {31'd0, nonce_valid}, 32'd0);
    chk("drain.out",   nonce_out, 32'd0);

    // Ack held high five cycles pops exactly one entry.
    step(1, 32'h400, 0, 0, "hold.fill", 1'b1);
    step(1, 32'h401, 0, 0, "hold.fill", 1'b1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, "hold.ack", 1'b1);
    chk("hold.count", {28'd0, fifo_count}, 32'd1);
    chk("hold.head",  nonce_out, 32'h401 - OFS);
    step(0, 0, 0, 0, "hold.lo", 1'b1);
    // Rising ack on empty must not be remembered.
    step(0, 0, 1, 0, "pop1", 1'b1);
    step(0, 0, 0, 0, "pop1.lo", 1'b1);
    step(0, 0, 1, 0, "emptyack", 1'b1);
    step(1, 32'h500, 1, 0, "emptyack.push", 1'b1);
    step(0, 0, 1, 0, "emptyack.hold", 1'b1);
    chk("emptyack.count", {28'd0, fifo_count}, 32'd1);
    step(0, 0, 0, 0, "e.lo", 1'b1);
    step(0, 0, 1, 0, "e.pop", 1'b1);
    step(0, 0, 0, 0, "e.lo2", 1'b1);

    // Full behaviour.
    for (int i = 0; i < 8; i++) step(1, 32'h300 + i, 0, 0, "full.fill", 1'b1);
    step(1, 32'h3F0, 0, 0, "full.drop", 1'b1);
    chk("full.ovf",   {31'd0, overflow}, 32'd1);
    chk("full.drop",  {24'd0, drop_count}, 32'd1);
    chk("full.count", {28'd0, fifo_count}, 32'd8);
    step(1, 32'h3F1, 1, 0, "full.pushpop", 1'b1);
    chk("pushpop.count", {28'd0, fifo_count}, 32'd8);
    chk("pushpop.drop",  {24'd0, drop_count}, 32'd1);
    chk("pushpop.head",  nonce_out, 32'h301 - OFS);
    step(0, 0, 0, 0, "full.lo", 1'b1);
    for (int i = 0; i < 300; i++) step(1, 32'h1000 + i, 0, 0, "sat", 1'b0);
    chk_model("sat");
    chk("sat.drop", {24'd0, drop_count}, 32'd255);

    // Drain to three entries with overflow set, then flush with a found.
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, "to3.hi", 1'b1);
      step(0, 0, 0, 0, "to3.lo", 1'b1);
    end
    chk("to3.count", {28'd0, fifo_count}, 32'd3);
    chk("to3.ovf",   {31'd0, overflow}, 32'd1);
    step(1, 32'h777, 1, 1, "flush", 1'b1);
    chk("flush.count", {28'd0, fifo_count}, 32'd0);
    chk("flush.valid", {31'd0, nonce_valid}, 32'd0);
    chk("flush.ovf",   {31'd0, overflow}, 32'd0);
    chk("flush.drop",  {24'd0, drop_count}, 32'd0);
    // ack_q tracked ack=1 through flush, so holding it produces no pop.
    step(1, 32'h800, 1, 0, "postflush", 1'b1);
    step(0, 0, 1, 0, "postflush.hold", 1'b1);
    chk("postflush.count", {28'd0, fifo_count}, 32'd1);
    step(1, 32'h801, 0, 0, "pre.rst", 1'b1);

    // Async reset mid-cycle: outputs clear before the next clock edge.
    #2 reset = 1'b1;
    #1;
    chk("arst.valid", {31'd0, nonce_valid}, 32'd0);
    chk("arst.out",   nonce_out, 32'd0);
    chk("arst.count", {28'd0, fifo_count}, 32'd0);
    model_reset();
    found = 0; ack = 0; flush = 0;
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0, 0, "arst.idle", 1'b1);

    // Found held four cycles with a fixed nonce.
    for (int i = 0; i < 4; i++) step(1, 32'h200, 0, 0, "dup", 1'b1);
`ifdef GNR_DUP_FILTER_EN
    chk("dup.count", {28'd0, fifo_count}, 32'd1);
`else
    chk("dup.count", {28'd0, fifo_count}, 32'd4);
`endif
    chk("dup.drop", {24'd0, drop_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
